// File: rtl/cello_lut_pkg.sv
// Shared types and sizing helpers for the cello truth-table evaluator.
// The optional reload path is controlled by the CFG_LOAD_EN macro in the users of this package.
package cello_lut_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EVAL,
        OUT
    } lut_state_e;

    localparam int MAX_N_IN = 6;
    localparam int SETTLE_W = 4;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/cello_tt_loader.sv
// Serial truth-table loader: MSB-first shadow shift, saturating bit count, commit/error pulses.
// Instantiated by cello_lut_eval only when CFG_LOAD_EN is defined.
module cello_tt_loader
    import cello_lut_pkg::*;
#(
    parameter int N_IN = 4,
    parameter logic [tt_width(N_IN)-1:0] TT_INIT = 16'h3B60
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      take,
    input  logic                      cfg_bit,
    input  logic                      cfg_last,
    output logic [tt_width(N_IN)-1:0] active_tt,
    output logic                      cfg_done,
    output logic                      cfg_err
);
    localparam int TT_W  = tt_width(N_IN);
    localparam int CNT_W = MAX_N_IN + 1;

    logic [TT_W-1:0]  shadow;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            count     <= '0;
            active_tt <= TT_INIT;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            if (take) begin
                if (cfg_last) begin
                    // The final bit completes the table only if exactly TT_W-1 preceded it.
                    if (count == CNT_W'(TT_W - 1)) begin
                        active_tt <= {shadow[TT_W-2:0], cfg_bit};
                        cfg_done  <= 1'b1;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                    shadow <= '0;
                    count  <= '0;
                end else if (count < CNT_W'(TT_W)) begin
                    shadow <= {shadow[TT_W-2:0], cfg_bit};
                    count  <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cello_lut_eval.sv
// Registered truth-table evaluator: accept a vector, settle for SETTLE cycles, return the table bit.
// Define CFG_LOAD_EN to include the serial run-time table reload (cello_tt_loader).
module cello_lut_eval
    import cello_lut_pkg::*;
#(
    parameter int N_IN = 4,
    parameter logic [tt_width(N_IN)-1:0] TT_INIT = 16'h3B60,
    parameter int SETTLE = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic [N_IN-1:0] out_idx,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            cfg_bit,
    input  logic            cfg_last,
    output logic            cfg_done,
    output logic            cfg_err
);
    localparam int TT_W = tt_width(N_IN);

    lut_state_e          state;
    logic [SETTLE_W-1:0] cnt;
    logic [N_IN-1:0]     vec;
    logic [TT_W-1:0]     active_tt;

`ifdef CFG_LOAD_EN
    logic cfg_take;

    // A pending configuration bit blocks input acceptance so loads win ties in IDLE.
    assign in_ready  = rst_n && (state == IDLE) && !cfg_valid;
    assign cfg_ready = rst_n && ((state == IDLE) || (state == LOAD));
    assign cfg_take  = cfg_valid && cfg_ready;

    cello_tt_loader #(
        .N_IN    (N_IN),
        .TT_INIT (TT_INIT)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .take      (cfg_take),
        .cfg_bit   (cfg_bit),
        .cfg_last  (cfg_last),
        .active_tt (active_tt),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );
`else
    logic unused_cfg;

    assign in_ready   = rst_n && (state == IDLE);
    assign cfg_ready  = 1'b0;
    assign cfg_done   = 1'b0;
    assign cfg_err    = 1'b0;
    assign active_tt  = TT_INIT;
    assign unused_cfg = ^{cfg_valid, cfg_bit, cfg_last};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            vec       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vec   <= in_vec;
                        cnt   <= SETTLE_W'(SETTLE - 1);
                        state <= EVAL;
                    end
`ifdef CFG_LOAD_EN
                    else if (cfg_take && !cfg_last) begin
                        state <= LOAD;
                    end
`endif
                end
`ifdef CFG_LOAD_EN
                LOAD: begin
                    if (cfg_valid && cfg_last) begin
                        state <= IDLE;
                    end
                end
`endif
                EVAL: begin
                    // The table is sampled only at the end of settling.
                    if (cnt == '0) begin
                        out_bit   <= active_tt[vec];
                        out_idx   <= vec;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cello_lut_eval.sv
// Self-checking bench for cello_lut_eval: directed vectors plus a per-cycle reference model.
// Load-path scenarios run when CFG_LOAD_EN is defined; otherwise the tied-off cfg path is checked.
module tb_cello_lut_eval;
    localparam int N_IN = 4;
    localparam int TT_W = 16;
    localparam int SETTLE = 3;
    localparam logic [TT_W-1:0] TT_INIT = 16'h3B60;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid, out_ready, out_bit;
    logic [N_IN-1:0] out_idx;
    logic            cfg_valid, cfg_ready, cfg_bit, cfg_last, cfg_done, cfg_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    cello_lut_eval #(
        .N_IN    (N_IN),
        .TT_INIT (TT_INIT),
        .SETTLE  (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_idx   (out_idx),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bit   (cfg_bit),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected results keyed by the cycle they must appear.
    typedef struct {
        int              due;
        logic            b;
        logic [N_IN-1:0] idx;
    } exp_t;

    exp_t            q[$];
    logic            bits[$];
    logic [TT_W-1:0] tt_model = TT_INIT;
    int              exp_done_cyc = -10;
    int              exp_err_cyc = -10;
    logic            exp_v;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                bits.delete();
                tt_model = TT_INIT;
                exp_done_cyc = -10;
                exp_err_cyc = -10;
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 0);
            end else begin
                exp_v = (q.size() > 0) && (cyc >= q[0].due);
                check("mdl_out_valid", out_valid, exp_v);
                if (exp_v && out_valid) begin
                    check("mdl_out_bit", out_bit, q[0].b);
                    check("mdl_out_idx", out_idx, q[0].idx);
                end
                check("mdl_cfg_done", cfg_done, cyc == exp_done_cyc);
                check("mdl_cfg_err", cfg_err, cyc == exp_err_cyc);
                if (exp_v && out_valid && out_ready) void'(q.pop_front());
                if (in_valid && in_ready)
                    q.push_back('{due: cyc + 1 + SETTLE, b: tt_model[in_vec], idx: in_vec});
`ifdef CFG_LOAD_EN
                if (cfg_valid && cfg_ready) begin
                    bits.push_back(cfg_bit);
                    if (cfg_last) begin
                        if (bits.size() == TT_W) begin
                            for (int i = 0; i < TT_W; i++) tt_model[TT_W-1-i] = bits[i];
                            exp_done_cyc = cyc + 1;
                        end else begin
                            exp_err_cyc = cyc + 1;
                        end
                        bits.delete();
                    end
                end
`else
                check("tied_cfg_ready", cfg_ready, 0);
`endif
            end
        end
    end

    task automatic eval_vec(input logic [N_IN-1:0] v, input logic exp_b, input int hold,
                            input bit with_cfg);
        int k;
        int lat;
        @(posedge clk);
        #1;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_vec    = v;
        if (with_cfg) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b0;
            cfg_last  = 1'b0;
        end
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (with_cfg) check("in_ready_cfg_ignored", in_ready, 1);
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid  = 1'b0;
            cfg_valid = 1'b0;
            out_ready = 1'b1;
            return;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        check("out_bit_lit", out_bit, exp_b);
        check("out_idx_lit", out_idx, v);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_bit", out_bit, exp_b);
            check("hold_out_idx", out_idx, v);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

`ifdef CFG_LOAD_EN
    task automatic load_bits(input logic [63:0] val, input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cfg_valid = 1'b1;
            cfg_bit   = val[n-1-i];
            cfg_last  = (i == n - 1);
            k = 0;
            @(negedge clk);
            while (!cfg_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!cfg_ready) check("cfg_ready_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask
`endif

    initial begin
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        cfg_last  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_bit", out_bit, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_cfg_done", cfg_done, 0);
        check("reset_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", in_ready, 1);

        // Default table 16'h3B60.
        eval_vec(4'h5, 1'b1, 0, 1'b0);
        eval_vec(4'h0, 1'b0, 0, 1'b0);
        eval_vec(4'hF, 1'b0, 0, 1'b0);
        eval_vec(4'hB, 1'b1, 0, 1'b0);
        eval_vec(4'h6, 1'b1, 5, 1'b0);

`ifdef CFG_LOAD_EN
        // Short load is discarded.
        load_bits(64'h2AB, 10);
        check("short_cfg_err", cfg_err, 1);
        check("short_cfg_done", cfg_done, 0);
        @(posedge clk);
        #1;
        check("short_err_pulse_end", cfg_err, 0);
        eval_vec(4'h5, 1'b1, 0, 1'b0);

        // Configuration wins a tie with an input vector in IDLE.
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        cfg_last  = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 4'h7;
        @(negedge clk);
        check("tie_in_ready", in_ready, 0);
        check("tie_cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("load_in_ready", in_ready, 0);
        load_bits(64'h5, 3);
        check("tie_cfg_err", cfg_err, 1);

        // Full reload of 16'h00FF.
        load_bits(64'h00FF, 16);
        check("full_cfg_done", cfg_done, 1);
        check("full_cfg_err", cfg_err, 0);
        @(posedge clk);
        #1;
        check("full_done_pulse_end", cfg_done, 0);
        eval_vec(4'h3, 1'b1, 0, 1'b0);
        eval_vec(4'h8, 1'b0, 0, 1'b0);
`else
        // Without the load path a simultaneous cfg_valid must not block input.
        eval_vec(4'h7, 1'b0, 0, 1'b1);
        check("tied_cfg_done", cfg_done, 0);
        check("tied_cfg_err", cfg_err, 0);
`endif

        // Reset in the middle of EVAL aborts the evaluation.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_vec   = 4'h5;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("rst_eval_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_eval_rst_in_ready", in_ready, 0);
        check("mid_eval_rst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("no_valid_after_rst", out_valid, 0);
        end
        eval_vec(4'h5, 1'b1, 0, 1'b0);
        eval_vec(4'h8, 1'b1, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
